// File: rtl/pc_sequenciador_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Next-address source encoding and stack error flag positions.
package pc_sequenciador_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_DESVIO,
    SEL_SALTO,
    SEL_CHAMADA,
    SEL_RETORNO
  } sel_t;

  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 0;

endpackage

// File: rtl/pc_sequenciador_pilha_retorno.sv
// Return-address stack: circular write pointer plus occupancy count.
// A push into a full stack silently replaces the oldest entry.
module pilha_retorno
  import pc_sequenciador_pkg::*;
#(
  parameter int LARGURA    = 16,
  parameter int PROF_PILHA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] dado,
  output logic [LARGURA-1:0] topo,
  output logic               vazia,
  output logic               cheia,
  output logic               overflow,
  output logic               underflow
);

  localparam int PW = $clog2(PROF_PILHA);
  localparam int CW = PW + 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LARGURA-1:0] mem_q [PROF_PILHA];
  logic [LARGURA-1:0] mem_d [PROF_PILHA];

  assign vazia     = (cnt_q == '0);
  assign cheia     = (cnt_q == CW'(PROF_PILHA));
  assign topo      = mem_q[ptr_q - PW'(1)];
  assign overflow  = push && !pop && cheia;
  assign underflow = pop && vazia;

  // ptr_q points at the next free slot, which is the oldest entry when full
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (pop) begin
      if (!vazia) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end else if (push) begin
      mem_d[ptr_q] = dado;
      ptr_d        = ptr_q + PW'(1);
      if (!cheia) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequenciador.sv
// Fetch-stage program counter: priority next-address mux, adder,
// registered fetch address, return-address stack and sticky error flags.
module pc_sequenciador
  import pc_sequenciador_pkg::*;
#(
  parameter int LARGURA    = 16,
  parameter int PASSO      = 1,
  parameter int END_RESET  = 0,
  parameter int PROF_PILHA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               desvio,
  input  logic [LARGURA-1:0] offset,
  input  logic               salto,
  input  logic               retorno,
  input  logic               chamada,
  input  logic [LARGURA-1:0] endSalto,
  output logic [LARGURA-1:0] endAtual,
  output logic [LARGURA-1:0] endSeq,
  output logic               pilhaVazia,
  output logic               pilhaCheia,
  output logic [1:0]         erroPilha
);

  logic [LARGURA-1:0] end_atual_q, end_atual_d;
  logic [1:0]         erro_q, erro_d;
  logic [LARGURA-1:0] topo;
  logic               push, pop, ovf, unf;
  sel_t               sel;

  assign endSeq     = end_atual_q + LARGURA'(PASSO);
  assign endAtual   = end_atual_q;
  assign erroPilha  = erro_q;

  // A stalled cycle drops every strobe, so the stack never moves
  assign pop  = !stall && retorno;
  assign push = !stall && !retorno && chamada;

  pilha_retorno #(
    .LARGURA    (LARGURA),
    .PROF_PILHA (PROF_PILHA)
  ) u_pilha (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .dado      (endSeq),
    .topo      (topo),
    .vazia     (pilhaVazia),
    .cheia     (pilhaCheia),
    .overflow  (ovf),
    .underflow (unf)
  );

  always_comb begin
    sel = SEL_SEQ;
    if (retorno) begin
      if (!pilhaVazia) sel = SEL_RETORNO;
    end else if (chamada) begin
      sel = SEL_CHAMADA;
    end else if (salto) begin
      sel = SEL_SALTO;
    end else if (desvio) begin
      sel = SEL_DESVIO;
    end
  end

  always_comb begin
    end_atual_d = end_atual_q;
    erro_d      = erro_q;
    if (!stall) begin
      unique case (sel)
        SEL_RETORNO: end_atual_d = topo;
        SEL_CHAMADA: end_atual_d = endSalto;
        SEL_SALTO:   end_atual_d = endSalto;
        SEL_DESVIO:  end_atual_d = endSeq + offset;
        default:     end_atual_d = endSeq;
      endcase
      erro_d[ERR_OVF] = erro_q[ERR_OVF] | ovf;
      erro_d[ERR_UNF] = erro_q[ERR_UNF] | unf;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      end_atual_q <= LARGURA'(END_RESET);
      erro_q      <= '0;
    end else begin
      end_atual_q <= end_atual_d;
      erro_q      <= erro_d;
    end
  end

endmodule

// File: tb/tb_pc_sequenciador.sv
// Directed bench for pc_sequenciador: vector table plus
// hand-written nested-call and reset-override sequences.
module tb_pc_sequenciador;

  logic        clock = 1'b0;
  logic        reset, stall, desvio, salto, retorno, chamada;
  logic [15:0] offset, endSalto;
  logic [15:0] endAtual, endSeq;
  logic        pilhaVazia, pilhaCheia;
  logic [1:0]  erroPilha;

  int n_pass = 0;
  int n_total = 0;

  pc_sequenciador #(
    .LARGURA(16), .PASSO(1), .END_RESET(0), .PROF_PILHA(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .desvio     (desvio),
    .offset     (offset),
    .salto      (salto),
    .retorno    (retorno),
    .chamada    (chamada),
    .endSalto   (endSalto),
    .endAtual   (endAtual),
    .endSeq     (endSeq),
    .pilhaVazia (pilhaVazia),
    .pilhaCheia (pilhaCheia),
    .erroPilha  (erroPilha)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st, dv, sa, rt, ch;
    logic [15:0] off, es;
    logic [15:0] pc;
    logic        v, c;
    logic [1:0]  e;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(logic st, logic dv, logic sa, logic rt,
                              logic ch, logic [15:0] off, logic [15:0] es,
                              logic [15:0] pc, logic v, logic c,
                              logic [1:0] e);
    vec_t r;
    r.st = st; r.dv = dv; r.sa = sa; r.rt = rt; r.ch = ch;
    r.off = off; r.es = es; r.pc = pc; r.v = v; r.c = c; r.e = e;
    return r;
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic chk_all(string nm, logic [15:0] pc, logic v, logic c,
                         logic [1:0] e);
    chk({nm, ".endAtual"}, endAtual, pc);
    chk({nm, ".endSeq"}, endSeq, pc + 16'd1);
    chk({nm, ".vazia"}, 16'(pilhaVazia), 16'(v));
    chk({nm, ".cheia"}, 16'(pilhaCheia), 16'(c));
    chk({nm, ".erro"}, 16'(erroPilha), 16'(e));
  endtask

  task automatic cyc(logic rs, logic st, logic dv, logic sa, logic rt,
                     logic ch, logic [15:0] off, logic [15:0] es);
    @(negedge clock);
    reset = rs; stall = st; desvio = dv; salto = sa;
    retorno = rt; chamada = ch; offset = off; endSalto = es;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] links [4];
    links[0] = 16'h0401; links[1] = 16'h0301;
    links[2] = 16'h0201; links[3] = 16'h0101;

    //          st dv sa rt ch off      es       pc       v  c  e
    vt[0]  = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0001, 1, 0, 2'b00);
    vt[1]  = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0002, 1, 0, 2'b00);
    vt[2]  = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0003, 1, 0, 2'b00);
    vt[3]  = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0004, 1, 0, 2'b00);
    vt[4]  = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0005, 1, 0, 2'b00);
    vt[5]  = mk(0, 1, 0, 0, 0, 16'hFFFD, 16'h0,   16'h0003, 1, 0, 2'b00);
    vt[6]  = mk(0, 0, 1, 0, 0, 16'h0,    16'h5,   16'h0005, 1, 0, 2'b00);
    vt[7]  = mk(0, 1, 0, 0, 0, 16'd10,   16'h0,   16'h0010, 1, 0, 2'b00);
    vt[8]  = mk(0, 1, 1, 0, 0, 16'h7,    16'h10,  16'h0010, 1, 0, 2'b00);
    vt[9]  = mk(0, 0, 0, 0, 1, 16'h0,    16'h40,  16'h0040, 0, 0, 2'b00);
    vt[10] = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0041, 0, 0, 2'b00);
    vt[11] = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0042, 0, 0, 2'b00);
    vt[12] = mk(0, 0, 0, 1, 0, 16'h0,    16'h0,   16'h0011, 1, 0, 2'b00);
    vt[13] = mk(1, 1, 0, 0, 0, 16'd100,  16'h0,   16'h0011, 1, 0, 2'b00);
    vt[14] = mk(1, 0, 0, 0, 1, 16'h0,    16'h80,  16'h0011, 1, 0, 2'b00);
    vt[15] = mk(1, 1, 0, 0, 1, 16'h5,    16'h90,  16'h0011, 1, 0, 2'b00);
    vt[16] = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0012, 1, 0, 2'b00);
    vt[17] = mk(0, 0, 1, 1, 0, 16'h0,    16'h77,  16'h0013, 1, 0, 2'b01);
    vt[18] = mk(0, 0, 1, 0, 0, 16'h0,    16'hFFFF,16'hFFFF, 1, 0, 2'b01);
    vt[19] = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,   16'h0000, 1, 0, 2'b01);
    vt[20] = mk(0, 0, 0, 0, 1, 16'h0,    16'h100, 16'h0100, 0, 0, 2'b01);
    vt[21] = mk(0, 0, 0, 1, 1, 16'h0,    16'h200, 16'h0001, 1, 0, 2'b01);

    cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk_all("reset", 16'h0000, 1'b1, 1'b0, 2'b00);

    for (int i = 0; i < 22; i++) begin
      cyc(0, vt[i].st, vt[i].dv, vt[i].sa, vt[i].rt, vt[i].ch,
          vt[i].off, vt[i].es);
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].v, vt[i].c, vt[i].e);
    end

    // stall must also hold a full stack with a pending return
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk_all("reset2", 16'h0000, 1'b1, 1'b0, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 16'h0, 16'(k * 16'h100));
      chk_all($sformatf("call%0d", k), 16'(k * 16'h100), 1'b0,
              (k >= 4), (k == 5) ? 2'b10 : 2'b00);
    end
    cyc(0, 1, 0, 0, 1, 0, 16'h0, 16'h0);
    chk_all("stall_full", 16'h0500, 1'b0, 1'b1, 2'b10);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
      chk_all($sformatf("ret%0d", k), links[k], (k == 3), 1'b0, 2'b10);
    end
    cyc(0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
    chk_all("ret_empty", 16'h0102, 1'b1, 1'b0, 2'b11);

    // reset overrides a same-cycle call and clears sticky flags
    cyc(1, 0, 0, 0, 0, 1, 16'h0, 16'h300);
    chk_all("reset_call", 16'h0000, 1'b1, 1'b0, 2'b00);
    cyc(0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
    chk_all("ret_after_rst", 16'h0001, 1'b1, 1'b0, 2'b01);
    idle();
    chk_all("seq_after", 16'h0002, 1'b1, 1'b0, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequenciador.md
# pc_sequenciador

Parametrised program-counter sequencer for the 16-bit MIPS datapath and its successor widths. It holds the current fetch address and selects the next one from: sequential increment, PC-relative branch, absolute jump, call, or return. It adds a hardware return-address stack for call/return, a stall hold and sticky stack-error flags. It sits in the fetch stage, feeds the instruction memory address and receives redirects from decode/execute.

## Interface
- LARGURA, 16: address width in bits (≥8).
- PASSO, 1: increment per instruction, in address units (word-addressed memory).
- END_RESET, 0: fetch address loaded on reset.
- PROF_PILHA, 4: return-stack depth; power of two, ≥2.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all state this cycle.
- desvio  in  1  take PC-relative branch.
- offset  in  LARGURA  signed branch displacement, two's complement.
- salto  in  1  absolute jump.
- retorno  in  1  return: pop stack, jump to popped address.
- chamada  in  1  call: push return address, jump to endSalto.
- endSalto  in  LARGURA  jump/call target.
- endAtual  out  LARGURA  current fetch address (registered).
- endSeq  out  LARGURA  endAtual + PASSO (combinational; the call link value).
- pilhaVazia  out  1  stack holds 0 entries.
- pilhaCheia  out  1  stack holds PROF_PILHA entries.
- erroPilha  out  2  sticky flags: [1] overflow, [0] underflow.

## Operation
- Next-address priority, evaluated every rising edge: reset > stall > retorno > chamada > salto > desvio > sequential.
- reset: endAtual=END_RESET, stack count=0, erroPilha=0. Stack contents are don't-care.
- stall: endAtual, stack and flags all hold. Redirect strobes asserted in a stalled cycle are discarded. The producer re-asserts them after the stall.
- sequential: endAtual ← endAtual + PASSO.
- desvio: endAtual ← endAtual + PASSO + offset (relative to the next instruction).
- salto: endAtual ← endSalto.
- chamada: push endSeq, then endAtual ← endSalto.
  - When full: the push overwrites the oldest entry (circular), count stays PROF_PILHA, and erroPilha[1] is set.
- retorno: when not empty, endAtual ← top and count decrements.
  - When empty: no pop. Sequential advance is taken instead and erroPilha[0] is set.
- retorno and chamada in the same cycle: retorno wins; the call is dropped and does not push.
- All address arithmetic is modulo 2^LARGURA. Wrap-around from all-ones to 0 is silent and is not an error.
- erroPilha bits clear only on reset.

## Timing
- Single-cycle: a strobe sampled at edge N sets endAtual at edge N, visible after edge N.
- endSeq, pilhaVazia and pilhaCheia track registered state with no additional latency.
- Reset asserted mid-call or mid-return overrides that cycle entirely; no push/pop takes effect.
- Stack push and pop are committed on the same edge as the endAtual update.

## Structure
- Shared package/header holds:
  - next-source select encoding: SEL_SEQ, SEL_DESVIO, SEL_SALTO, SEL_CHAMADA, SEL_RETORNO;
  - erroPilha bit indices: ERR_OVF=1, ERR_UNF=0.
- Sub-module pilha_retorno implements the return-address stack:
  - parameters LARGURA, PROF_PILHA;
  - ports clock, reset, push, pop, dado, topo, vazia, cheia, overflow, underflow;
  - circular pointer plus count.
- Top level holds the priority mux, the adder and endAtual.

## Test plan
- Reset, then 3 free cycles → endAtual 0,1,2,3; pilhaVazia=1; erroPilha=0.
- At endAtual=5, desvio with offset=-3 → endAtual=3. With offset=+10 → 5+1+10=16.
- chamada endSalto=0x0040 at endAtual=0x0010, 2 sequential cycles, then retorno → endAtual 0x0040, 0x0041, 0x0042, 0x0011.
- 5 nested calls with PROF_PILHA=4 → erroPilha=2'b10, pilhaCheia=1. Then 4 returns yield links of calls 5,4,3,2. A 5th return advances sequentially and sets erroPilha=2'b11.
- stall held 3 cycles while desvio and chamada pulse → endAtual and stack unchanged. After release, sequential advance resumes.
- LARGURA=16 with endAtual=0xFFFF, sequential → 0x0000, no flag. Simultaneous retorno and chamada with one entry → pops only; count=0.
